// File: rtl/mux_sel_scanner.sv
// Steps a 4:1 mux select through channels 0..3, samples the mux output on the
// last dwell cycle of each channel and offers the four samples as one word.
module mux_sel_scanner #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       z,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] dwell_q, dwell_d;
    logic [2:0] sample_q, sample_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    // Valid/ready: out_valid rises with the word and stays high, with out_data
    // stable, until an edge sees out_valid & out_ready; abort withdraws it.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        dwell_d     = dwell_q;
        sample_d    = sample_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN;
                    ch_d    = 2'd0;
                    dwell_d = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    dwell_d = 4'd0;
                    busy_d  = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = 4'd0;
                    case (ch_q)
                        2'd0: sample_d[0] = z;
                        2'd1: sample_d[1] = z;
                        2'd2: sample_d[2] = z;
                        default: ;
                    endcase
                    if (ch_q == 2'd3) begin
                        out_data_d  = {z, sample_q};
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            HOLD: begin
                // Select stays on channel 3 while the word waits.
                if (abort) begin
                    state_d     = IDLE;
                    ch_d        = 2'd0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    ch_d        = 2'd0;
                    dwell_d     = 4'd0;
                    if (cont) begin
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                ch_d        = 2'd0;
                dwell_d     = 4'd0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= 2'd0;
            dwell_q     <= 4'd0;
            sample_q    <= 3'd0;
            out_data_q  <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            dwell_q     <= dwell_d;
            sample_q    <= sample_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign s1        = ch_q[1];
    assign s0        = ch_q[0];
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: two instances (DWELL=2 and DWELL=1),
// each closing the loop through a behavioural 4:1 mux.
module tb_mux_sel_scanner;

  logic       clk;
  logic       rst;
  logic       start, cont, abort, out_ready;
  logic [3:0] i_a;
  logic       z_a, s1_a, s0_a, busy_a, out_valid_a;
  logic [3:0] out_data_a;

  logic       start_b, out_ready_b;
  logic [3:0] i_b;
  logic       z_b, s1_b, s0_b, busy_b, out_valid_b;
  logic [3:0] out_data_b;

  logic [3:0] exp_q[$];
  logic [3:0] exp_word;
  int         errors;
  int         checks;

  // 4:1 mux: z = i[{s1,s0}]
  assign z_a = i_a[{s1_a, s0_a}];
  assign z_b = i_b[{s1_b, s0_b}];

  mux_sel_scanner #(.DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .z(z_a), .s1(s1_a), .s0(s0_a), .busy(busy_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  mux_sel_scanner #(.DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(1'b0), .abort(1'b0),
    .z(z_b), .s1(s1_b), .s0(s0_b), .busy(busy_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid_a}, 32'd0);
    check({tag, "_s"}, {30'd0, s1_a, s0_a}, 32'd0);
  endtask

  // scoreboard pop on a presented word
  task automatic expect_word_a(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid_a}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_word = exp_q.pop_front();
      check({tag, "_data"}, {28'd0, out_data_a}, {28'd0, exp_word});
    end
  endtask

  // start pulse; returns after the start edge E0
  task automatic start_a(input logic [3:0] word, input bit push);
    i_a = word;
    if (push) exp_q.push_back(word);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    start = 0; cont = 0; abort = 0; out_ready = 0; i_a = 4'h0;
    start_b = 0; out_ready_b = 0; i_b = 4'h0;
    repeat (2) tick();
    check("reset_data", {28'd0, out_data_a}, 32'd0);
    check_idle_a("reset");
    rst = 1'b0;
    repeat (3) tick();
    check_idle_a("post_reset");

    // single scan, select sequence and latency
    start_a(4'b1010, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("scan_s_%0d", k), {30'd0, s1_a, s0_a}, k / 2);
      check($sformatf("scan_busy_%0d", k), {31'd0, busy_a}, 32'd1);
      check($sformatf("scan_novalid_%0d", k), {31'd0, out_valid_a}, 32'd0);
      if (k < 7) tick();
    end
    tick();
    expect_word_a("single");
    check("single_hold_s", {30'd0, s1_a, s0_a}, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle_a("single_accept");

    // backpressure with an ignored start during HOLD
    start_a(4'b1010, 1'b1);
    repeat (8) tick();
    expect_word_a("bp");
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
      check($sformatf("bp_valid_%0d", k), {31'd0, out_valid_a}, 32'd1);
      check($sformatf("bp_data_%0d", k), {28'd0, out_data_a}, 32'hA);
      check($sformatf("bp_s_%0d", k), {30'd0, s1_a, s0_a}, 32'd3);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle_a("bp_accept");
    repeat (3) tick();
    check_idle_a("bp_start_not_queued");

    // continuous mode, two back-to-back frames
    cont = 1'b1;
    start_a(4'b0101, 1'b1);
    repeat (8) tick();
    expect_word_a("cont1");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    i_a = 4'b0011;
    exp_q.push_back(4'b0011);
    check("cont_restart_s", {30'd0, s1_a, s0_a}, 32'd0);
    check("cont_restart_busy", {31'd0, busy_a}, 32'd1);
    check("cont_restart_valid", {31'd0, out_valid_a}, 32'd0);
    repeat (8) tick();
    expect_word_a("cont2");
    cont = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle_a("cont_end");

    // abort during SCAN at the third edge after start
    start_a(4'b1010, 1'b0);
    repeat (2) tick();
    check("abort_pre_s", {30'd0, s1_a, s0_a}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_a("abort_scan");
    check("abort_scan_data", {28'd0, out_data_a}, 32'h3);
    repeat (10) tick();
    check_idle_a("abort_scan_quiet");

    // abort with out_ready and cont in HOLD
    start_a(4'b1010, 1'b1);
    repeat (8) tick();
    expect_word_a("abort_hold_word");
    abort = 1'b1; out_ready = 1'b1; cont = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0; cont = 1'b0;
    check_idle_a("abort_hold");
    check("abort_hold_data", {28'd0, out_data_a}, 32'hA);
    tick();
    check_idle_a("abort_hold_cont_ignored");

    // DWELL=1 instance
    i_b = 4'b1111;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d1_s_%0d", k), {30'd0, s1_b, s0_b}, k);
      check($sformatf("d1_novalid_%0d", k), {31'd0, out_valid_b}, 32'd0);
      tick();
    end
    check("d1_valid", {31'd0, out_valid_b}, 32'd1);
    check("d1_data", {28'd0, out_data_b}, 32'hF);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    check("d1_accept_busy", {31'd0, busy_b}, 32'd0);
    check("d1_accept_valid", {31'd0, out_valid_b}, 32'd0);

    // asynchronous reset mid-cycle while scanning
    start_a(4'b0110, 1'b0);
    repeat (3) tick();
    check("arst_pre_busy", {31'd0, busy_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_a("arst");
    check("arst_data", {28'd0, out_data_a}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_idle_a("arst_release");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
